// File: rtl/leb128_pkg.sv
// leb128_pkg
//   Shared definitions for the LEB128 pack/unpack family.
//   - maxlen(w): number of 7-bit groups needed to carry a w-bit value
//   - lenw(w):   width of a length field able to hold 0..maxlen(w)+1
//   - state_t:   decoder states (accumulate / drain overlong input)
//   - bit-index constants for the encoded byte layout
package leb128_pkg;

    // Encoded byte: bit 7 = continuation, bits 6:0 = payload
    localparam int CONT_BIT     = 7;
    localparam int SIGN_BIT     = 6;
    localparam int PAYLOAD_BITS = 7;

    typedef enum logic {
        ST_ACC   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    function automatic int maxlen(input int w);
        return (w + PAYLOAD_BITS - 1) / PAYLOAD_BITS;
    endfunction

    function automatic int lenw(input int w);
        return $clog2(maxlen(w) + 2);
    endfunction

endpackage

// File: rtl/leb128_out_reg.sv
// leb128_out_reg
//   Single-entry valid/ready holding register for a decoded result.
//   Ports:
//     clk, rst_n   - clock, synchronous active-low reset
//     load         - capture load_data (only asserted while ready is high)
//     load_data    - payload to hold
//     ready        - register can take a new payload this cycle
//     valid        - payload present
//     take         - consumer accepts the held payload
//     data         - held payload
module leb128_out_reg #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [PW-1:0] load_data,
    output logic          ready,
    output logic          valid,
    input  logic          take,
    output logic [PW-1:0] data
);

    // Free when empty, or when the held entry leaves in this same cycle,
    // which lets a new result replace the old one without a bubble.
    assign ready = !valid || take;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (take) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/leb128_stream_decoder.sv
// leb128_stream_decoder
//   Streaming LEB128 decoder: one encoded byte per cycle in, one decoded
//   value (with encoded length and error flag) out through a registered
//   valid/ready stage. Signed/unsigned mode is chosen per value.
//   Ports:
//     clk, rst_n            - clock, synchronous active-low reset
//     in_valid / in_ready   - byte channel handshake
//     in_data[7:0]          - encoded byte (bit7 continuation, 6:0 payload)
//     in_signed             - mode, sampled with the first byte of a value
//     out_valid / out_ready - result channel handshake
//     out_data[W-1:0]       - decoded value
//     out_len[LW-1:0]       - bytes consumed (MAXLEN+1 for overlong input)
//     out_err               - malformed or overlong encoding
module leb128_stream_decoder
    import leb128_pkg::*;
#(
    parameter int W      = 64,
    parameter int MAXLEN = maxlen(W),
    parameter int LW     = lenw(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    input  logic          in_signed,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [LW-1:0] out_len,
    output logic          out_err
);

    // Payload bits of the final group that still land inside the W-bit value
    localparam int U = W - PAYLOAD_BITS * (MAXLEN - 1);
    // Final-group payload bits that fall above bit W-1
    localparam logic [6:0] HI_MASK = 7'(7'h7f << U);
    localparam logic [LW-1:0] LEN_OVER = LW'(MAXLEN + 1);
    localparam logic [LW-1:0] LAST_K   = LW'(MAXLEN - 1);

    state_t        state;
    logic [W-1:0]  acc;
    logic [LW-1:0] cnt;
    logic          mode;

    logic          accept;
    logic          cont;
    logic          mode_eff;
    logic          last;
    logic          hi_err;
    logic [6:0]    payload;
    logic [6:0]    hi_bits;
    logic [W-1:0]  acc_next;
    logic [W-1:0]  ext_mask;
    logic [W-1:0]  value;

    logic              load;
    logic [W+LW:0]     load_data;
    logic [W+LW:0]     held;

    assign accept = in_valid && in_ready;

    // Datapath for the byte on the input: merge its payload into the
    // accumulator, then sign- or zero-extend as if it were the terminator.
    // Shifts past W-1 drop bits naturally, which gives both the truncation
    // of the final group and an empty extension mask when all W bits are
    // already covered.
    always_comb begin
        payload  = in_data[CONT_BIT-1:0];
        cont     = in_data[CONT_BIT];
        mode_eff = (cnt == '0) ? in_signed : mode;
        last     = (cnt == LAST_K);
        acc_next = acc | (W'(payload) << (PAYLOAD_BITS * 32'(cnt)));
        ext_mask = {W{1'b1}} << (PAYLOAD_BITS * (32'(cnt) + 1));
        value    = (mode_eff && payload[SIGN_BIT]) ? (acc_next | ext_mask) : acc_next;

        // The bits of the final group above the value must be a uniform
        // filler: all zero when unsigned, all zero or all one when signed.
        // The top in-range bit is not compared, so nine ff bytes closed by
        // 01 decode to -1 cleanly, while 02 marks the value malformed.
        hi_bits = payload & HI_MASK;
        if (mode_eff) begin
            hi_err = (hi_bits != 7'd0) && (hi_bits != HI_MASK);
        end else begin
            hi_err = (hi_bits != 7'd0);
        end
        if (!last) begin
            hi_err = 1'b0;
        end
    end

    // Result selection: a terminator in ACC emits the decoded value, a
    // terminator in DRAIN closes an overlong encoding with a fixed error
    // result.
    always_comb begin
        load      = 1'b0;
        load_data = '0;
        if (accept && !cont) begin
            load = 1'b1;
            if (state == ST_DRAIN) begin
                load_data = {1'b1, LEN_OVER, {W{1'b0}}};
            end else begin
                load_data = {hi_err, cnt + LW'(1), value};
            end
        end
    end

    // Decoder state. Nothing moves without an accepted byte, so bubbles and
    // backpressure (in_ready low) freeze the accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_ACC;
            acc   <= '0;
            cnt   <= '0;
            mode  <= 1'b0;
        end else if (accept) begin
            case (state)
                ST_ACC: begin
                    if (!cont) begin
                        acc <= '0;
                        cnt <= '0;
                    end else if (last) begin
                        state <= ST_DRAIN;
                        acc   <= '0;
                        cnt   <= '0;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + LW'(1);
                        if (cnt == '0) begin
                            mode <= in_signed;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!cont) begin
                        state <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

    leb128_out_reg #(
        .PW(W + LW + 1)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .ready     (in_ready),
        .valid     (out_valid),
        .take      (out_ready),
        .data      (held)
    );

    assign out_err  = held[W+LW];
    assign out_len  = held[W+LW-1:W];
    assign out_data = held[W-1:0];

endmodule
